// File: rtl/tick_sched_pkg.sv
// Shared constants and types for the tick_sched clock-enable scheduler.
package tick_sched_pkg;

    // Register map: 0..NCH-1 are channel divisors, 7 is the control register.
    localparam logic [2:0] ADDR_CTRL = 3'd7;

    // Control register bit that phase-aligns every enabled channel.
    localparam int CTRL_SYNC = 31;

    // Per-channel run state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/tick_chan.sv
// One scheduler channel: free-running counter with a shadowed divisor that is
// only swapped in at a terminal count, producing a tick pulse and a square wave.
module tick_chan
    import tick_sched_pkg::*;
#(
    parameter int              CW      = 24,
    parameter logic [CW-1:0]   DIV_RST = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,        // enable level in effect after this edge
    input  logic          sync,      // clear counter and square wave if enabled
    input  logic          div_we,
    input  logic [CW-1:0] div_data,
    output logic          tick,
    output logic          sclk,
    output logic          pending
);

    chan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] shd_q, shd_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          sclk_q, sclk_d;
    logic          term_s;

    // Next-state logic: disable beats sync, sync beats terminal count, and a
    // divisor write on the terminal-count edge loads the active divisor directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        tick_d  = 1'b0;
        sclk_d  = sclk_q;
        term_s  = (cnt_q == act_q);
        case (state_q)
            IDLE: begin
                cnt_d  = {CW{1'b0}};
                sclk_d = 1'b0;
                pend_d = 1'b0;
                if (en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
                if (div_we) begin
                    act_d = div_data;
                    shd_d = div_data;
                end else begin
                    act_d = act_q;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                    sclk_d  = 1'b0;
                    pend_d  = 1'b0;
                    if (div_we) begin
                        act_d = div_data;
                        shd_d = div_data;
                    end else if (pend_q) begin
                        act_d = shd_q;
                    end else begin
                        act_d = act_q;
                    end
                end else if (sync) begin
                    cnt_d  = {CW{1'b0}};
                    sclk_d = 1'b0;
                    if (div_we) begin
                        shd_d  = div_data;
                        pend_d = 1'b1;
                    end else begin
                        shd_d = shd_q;
                    end
                end else if (term_s) begin
                    cnt_d  = {CW{1'b0}};
                    tick_d = 1'b1;
                    sclk_d = ~sclk_q;
                    pend_d = 1'b0;
                    if (div_we) begin
                        act_d = div_data;
                        shd_d = div_data;
                    end else if (pend_q) begin
                        act_d = shd_q;
                    end else begin
                        act_d = act_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (div_we) begin
                        shd_d  = div_data;
                        pend_d = 1'b1;
                    end else begin
                        shd_d = shd_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
                sclk_d  = 1'b0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            act_q   <= DIV_RST;
            shd_q   <= DIV_RST;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            sclk_q  <= sclk_d;
        end
    end

    assign tick    = tick_q;
    assign sclk    = sclk_q;
    assign pending = pend_q;

endmodule

// File: rtl/tick_sched.sv
// Multi-channel clock-enable scheduler: write-port decode, channel enable mask
// and NCH independent tick_chan instances.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int            NCH     = 4,
    parameter int            CW      = 24,
    parameter logic [CW-1:0] DIV_RST = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [2:0]     wr_addr,
    input  logic [31:0]    wr_data,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sclk,
    output logic [NCH-1:0] en_mask,
    output logic [NCH-1:0] pending
);

    logic [NCH-1:0] en_mask_q, en_mask_d;
    logic           ctrl_we_s;
    logic           sync_s;
    logic           unused_s;

    // Reserved control bits and divisor bits above CW carry no meaning.
    assign unused_s = ^wr_data;

    // Control write decode: the new enable mask is handed to the channels on
    // the same edge so they start or stop together with en_mask.
    always_comb begin
        ctrl_we_s = wr_en && (wr_addr == ADDR_CTRL);
        if (ctrl_we_s) begin
            en_mask_d = wr_data[NCH-1:0];
            sync_s    = wr_data[CTRL_SYNC];
        end else begin
            en_mask_d = en_mask_q;
            sync_s    = 1'b0;
        end
    end

    // Enable mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_mask_q <= {NCH{1'b0}};
        end else begin
            en_mask_q <= en_mask_d;
        end
    end

    assign en_mask = en_mask_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        tick_chan #(
            .CW      (CW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en_mask_d[g]),
            .sync     (sync_s),
            .div_we   (wr_en && (wr_addr == 3'(g))),
            .div_data (wr_data[CW-1:0]),
            .tick     (tick[g]),
            .sclk     (sclk[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_tick_sched.sv
// Randomised scoreboard bench for tick_sched against a time-based reference model.
module tb_tick_sched;

    localparam int            NCH     = 4;
    localparam int            CW      = 24;
    localparam logic [CW-1:0] DIV_RST = 24'd3;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [2:0]     wr_addr;
    logic [31:0]    wr_data;
    logic [NCH-1:0] tick, sclk, en_mask, pending;

    always #5 clk = ~clk;

    tick_sched #(.NCH(NCH), .CW(CW), .DIV_RST(DIV_RST)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tick(tick), .sclk(sclk), .en_mask(en_mask), .pending(pending)
    );

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sclk;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a channel that started a period at edge S ticks at edge
    // S+act+1; everything else is event rules on top of that.
    int ecount;
    int m_on[NCH], m_start[NCH], m_act[NCH], m_shd[NCH], m_pend[NCH], m_sclk[NCH];

    task automatic model_reset();
        ecount = 0;
        for (int c = 0; c < NCH; c++) begin
            m_on[c] = 0; m_start[c] = 0; m_act[c] = int'(DIV_RST);
            m_shd[c] = int'(DIV_RST); m_pend[c] = 0; m_sclk[c] = 0;
        end
    endtask

    function automatic bit due_next(input int c);
        return (m_on[c] != 0) && ((ecount + 1 - m_start[c]) == m_act[c] + 1);
    endfunction

    task automatic model_step(input logic we, input logic [2:0] a, input logic [31:0] d,
                              output exp_t e);
        int  edge_n;
        bit  ctrl, sync, dw, due, new_on;
        int  dv;
        edge_n = ecount + 1;
        ctrl   = we && (a == 3'd7);
        sync   = ctrl && d[31];
        dv     = int'(d[CW-1:0]);
        e      = '0;
        for (int c = 0; c < NCH; c++) begin
            dw     = we && (int'(a) == c);
            new_on = ctrl ? d[c] : (m_on[c] != 0);
            due    = (m_on[c] != 0) && ((edge_n - m_start[c]) == m_act[c] + 1);
            if (m_on[c] == 0) begin
                if (dw) begin m_act[c] = dv; m_shd[c] = dv; end
                m_pend[c] = 0; m_sclk[c] = 0;
                if (new_on) m_start[c] = edge_n;
                m_on[c] = new_on ? 1 : 0;
            end else if (!new_on) begin
                m_on[c] = 0; m_sclk[c] = 0;
                if (dw) begin m_act[c] = dv; m_shd[c] = dv; end
                else if (m_pend[c] != 0) m_act[c] = m_shd[c];
                m_pend[c] = 0;
            end else if (sync) begin
                m_start[c] = edge_n; m_sclk[c] = 0;
                if (dw) begin m_shd[c] = dv; m_pend[c] = 1; end
            end else if (due) begin
                e.tick[c] = 1'b1; m_sclk[c] = 1 - m_sclk[c]; m_start[c] = edge_n;
                if (dw) begin m_act[c] = dv; m_shd[c] = dv; end
                else if (m_pend[c] != 0) m_act[c] = m_shd[c];
                m_pend[c] = 0;
            end else if (dw) begin
                m_shd[c] = dv; m_pend[c] = 1;
            end
            e.sclk[c] = (m_sclk[c] != 0);
            e.mask[c] = (m_on[c] != 0);
            e.pend[c] = (m_pend[c] != 0);
        end
        ecount = edge_n;
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge.
    task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        wr_en = we; wr_addr = a; wr_data = d;
        model_step(we, a, d, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic wait_due(input int c);
        for (int i = 0; i < 40 && !due_next(c); i++) idle(1);
    endtask

    task automatic chk(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    // Monitor: compare DUT outputs shortly after every edge with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({tick, sclk, en_mask, pending} !== e) begin
                    fails++;
                    $display("FAIL scoreboard @%0t: got tick=%b sclk=%b en=%b pend=%b required tick=%b sclk=%b en=%b pend=%b",
                             $time, tick, sclk, en_mask, pending, e.tick, e.sclk, e.mask, e.pend);
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [2:0]  a;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'd0;
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("reset_tick", tick, {NCH{1'b0}});
        chk("reset_sclk", sclk, {NCH{1'b0}});
        chk("reset_en_mask", en_mask, {NCH{1'b0}});
        chk("reset_pending", pending, {NCH{1'b0}});
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing may run.
        idle(20);

        // Basic divide-by-5 on channel 0.
        drive(1'b1, 3'd0, 32'd4);
        drive(1'b1, 3'd7, 32'h1);
        idle(25);

        // Mid-period divisor change becomes pending until the terminal count.
        idle(2);
        while (due_next(0)) idle(1);
        drive(1'b1, 3'd0, 32'hAB00_0009);
        idle(35);

        // Divisor write exactly on the terminal-count edge.
        wait_due(0);
        drive(1'b1, 3'd0, 32'd2);
        idle(12);

        // Disable exactly on the terminal-count edge.
        wait_due(0);
        drive(1'b1, 3'd7, 32'h0);
        idle(6);

        // Two channels, then SYNC phase alignment.
        drive(1'b1, 3'd0, 32'd2);
        drive(1'b1, 3'd1, 32'd5);
        drive(1'b1, 3'd7, 32'h3);
        idle(4);
        drive(1'b1, 3'd7, 32'h8000_0003);
        idle(20);

        // All channels at divisor 0, then asynchronous reset mid-run.
        drive(1'b1, 3'd7, 32'h0);
        for (int c = 0; c < NCH; c++) drive(1'b1, 3'(c), 32'd0);
        drive(1'b1, 3'd7, 32'hF);
        idle(4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_tick", tick, {NCH{1'b0}});
        chk("async_rst_sclk", sclk, {NCH{1'b0}});
        chk("async_rst_en_mask", en_mask, {NCH{1'b0}});
        chk("async_rst_pending", pending, {NCH{1'b0}});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(6);
        // Enable without writing a divisor: runs at the reset divisor.
        drive(1'b1, 3'd7, 32'h5);
        idle(15);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 25) begin
                a = 3'($urandom_range(0, 7));
                d = $urandom;
                if (a == 3'd7) d[31] = ($urandom_range(0, 9) == 0);
                else d[CW-1:0] = CW'($urandom_range(0, 10));
                drive(1'b1, a, d);
            end else begin
                idle(1);
            end
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
